// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (adds the BNEEX state).
package mips_ctrl_pkg;

    localparam int CTRL_STATE_W = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`ifdef MULTICYCLE_CTRL_BNE_EN
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
`else
        S_JEX     = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop and funct to the ALU operation code.
// Unknown funct falls back to add so the write-back still happens.
module mc_aludec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    // Decode ALU operation; add is the default for every unlisted code
    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    F_ADD:   alucontrol_o = ALU_ADD;
                    F_SUB:   alucontrol_o = ALU_SUB;
                    F_AND:   alucontrol_o = ALU_AND;
                    F_OR:    alucontrol_o = ALU_OR;
                    F_SLT:   alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the multicycle MIPS datapath.
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (bne support).
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrcA,
    output logic [1:0] alusrcB,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    state_t             cur;
    logic               pcwrite;
    logic               branch;
    logic [1:0]         aluop;
`ifdef MULTICYCLE_CTRL_BNE_EN
    logic               branch_ne;
`endif

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_W'(S_FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; reset shows FETCH with writes masked
    always_comb begin
        state_d  = STATE_W'(S_FETCH);
        pcwrite  = 1'b0;
        branch   = 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
        branch_ne = 1'b0;
`endif
        aluop    = ALUOP_ADD;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrcA  = 1'b0;
        alusrcB  = 2'b00;
        pcsrc    = 2'b00;
        cur      = reset ? S_FETCH : state_t'(state_q);
        case (cur)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcB = 2'b01;
                pcwrite = 1'b1;
                state_d = STATE_W'(S_DECODE);
            end
            S_DECODE: begin
                alusrcB = 2'b11;
                case (op)
                    OP_LW,
                    OP_SW:    state_d = STATE_W'(S_MEMADR);
                    OP_RTYPE: state_d = STATE_W'(S_RTYPEEX);
                    OP_BEQ:   state_d = STATE_W'(S_BEQEX);
                    OP_ADDI:  state_d = STATE_W'(S_ADDIEX);
                    OP_J:     state_d = STATE_W'(S_JEX);
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:   state_d = STATE_W'(S_BNEEX);
`endif
                    default:  state_d = STATE_W'(S_FETCH);
                endcase
            end
            S_MEMADR: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
                state_d = (op == OP_SW) ? STATE_W'(S_MEMWR)
                                        : STATE_W'(S_MEMRD);
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = STATE_W'(S_MEMWB);
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = STATE_W'(S_RTYPEWB);
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrcA = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_BNE_EN
            S_BNEEX: begin
                alusrcA   = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc     = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            S_ADDIEX: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
                state_d = STATE_W'(S_ADDIWB);
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = STATE_W'(S_FETCH);
        endcase
`ifdef MULTICYCLE_CTRL_BNE_EN
        pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);
`else
        pcen = pcwrite | (branch & zero);
`endif
        if (reset) begin
            pcen     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
        end
    end

    mc_aludec u_aludec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: driver queues expected
// per-cycle output vectors, a negedge monitor pops and compares them.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite;
    logic       iord, memtoreg, regdst, alusrcA;
    logic [1:0] alusrcB, pcsrc;
    logic [2:0] alucontrol;

    // {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrcA,
    //  alusrcB,pcsrc,alucontrol}
    localparam logic [14:0] V_RST    = 15'b0000_0000_01_00_010;
    localparam logic [14:0] V_FETCH  = 15'b1010_0000_01_00_010;
    localparam logic [14:0] V_DECODE = 15'b0000_0000_11_00_010;
    localparam logic [14:0] V_MEMADR = 15'b0000_0001_10_00_010;
    localparam logic [14:0] V_MEMRD  = 15'b0000_1000_00_00_010;
    localparam logic [14:0] V_MEMWB  = 15'b0001_0100_00_00_010;
    localparam logic [14:0] V_MEMWR  = 15'b0100_1000_00_00_010;
    localparam logic [14:0] V_RTWB   = 15'b0001_0010_00_00_010;
    localparam logic [14:0] V_BEQ_T  = 15'b1000_0001_00_01_110;
    localparam logic [14:0] V_BEQ_N  = 15'b0000_0001_00_01_110;
    localparam logic [14:0] V_ADDIEX = 15'b0000_0001_10_00_010;
    localparam logic [14:0] V_ADDIWB = 15'b0001_0000_00_00_010;
    localparam logic [14:0] V_JEX    = 15'b1000_0000_00_10_010;

    typedef struct {
        logic [14:0] v;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrcA    (alusrcA),
        .alusrcB    (alusrcB),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] v_rtex(input logic [2:0] alu);
        return {12'b0000_0001_00_00, alu};
    endfunction

    // Monitor: one expected vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t   e;
            logic [14:0] got;
            e   = sb_q.pop_front();
            got = {pcen, memwrite, irwrite, regwrite, iord, memtoreg,
                   regdst, alusrcA, alusrcB, pcsrc, alucontrol};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.v);
            end
        end
    end

    task automatic cyc(input logic r, input logic [5:0] o,
                       input logic [5:0] f, input logic z,
                       input logic [14:0] v, input string nm);
        exp_t e;
        reset = r;
        op    = o;
        funct = f;
        zero  = z;
        e.v    = v;
        e.name = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [2:0] alu,
                         input string nm);
        cyc(0, 6'b000000, f, 0, V_FETCH,     {nm, "_fetch"});
        cyc(0, 6'b000000, f, 0, V_DECODE,    {nm, "_decode"});
        cyc(0, 6'b000000, f, 0, v_rtex(alu), {nm, "_ex"});
        cyc(0, 6'b000000, f, 0, V_RTWB,      {nm, "_wb"});
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        // reset held across two edges with lw on op
        cyc(1, 6'b100011, 6'd0, 0, V_RST, "reset_c1");
        cyc(1, 6'b100011, 6'd0, 0, V_RST, "reset_c2");
        // lw: 5 cycles
        cyc(0, 6'b100011, 6'd0, 0, V_FETCH,  "lw_fetch");
        cyc(0, 6'b100011, 6'd0, 0, V_DECODE, "lw_decode");
        cyc(0, 6'b100011, 6'd0, 0, V_MEMADR, "lw_memadr");
        cyc(0, 6'b100011, 6'd0, 0, V_MEMRD,  "lw_memrd");
        cyc(0, 6'b100011, 6'd0, 0, V_MEMWB,  "lw_memwb");
        // sw: 4 cycles
        cyc(0, 6'b101011, 6'd0, 0, V_FETCH,  "sw_fetch");
        cyc(0, 6'b101011, 6'd0, 0, V_DECODE, "sw_decode");
        cyc(0, 6'b101011, 6'd0, 0, V_MEMADR, "sw_memadr");
        cyc(0, 6'b101011, 6'd0, 0, V_MEMWR,  "sw_memwr");
        // R-type for every funct, plus an unknown funct
        rtype(6'b100000, 3'b010, "rt_add");
        rtype(6'b100010, 3'b110, "rt_sub");
        rtype(6'b100100, 3'b000, "rt_and");
        rtype(6'b100101, 3'b001, "rt_or");
        rtype(6'b101010, 3'b111, "rt_slt");
        rtype(6'b111111, 3'b010, "rt_unk");
        // beq taken and not taken
        cyc(0, 6'b000100, 6'd0, 1, V_FETCH,  "beqt_fetch");
        cyc(0, 6'b000100, 6'd0, 1, V_DECODE, "beqt_decode");
        cyc(0, 6'b000100, 6'd0, 1, V_BEQ_T,  "beqt_ex");
        cyc(0, 6'b000100, 6'd0, 0, V_FETCH,  "beqn_fetch");
        cyc(0, 6'b000100, 6'd0, 0, V_DECODE, "beqn_decode");
        cyc(0, 6'b000100, 6'd0, 0, V_BEQ_N,  "beqn_ex");
        // addi: 4 cycles
        cyc(0, 6'b001000, 6'd0, 0, V_FETCH,  "addi_fetch");
        cyc(0, 6'b001000, 6'd0, 0, V_DECODE, "addi_decode");
        cyc(0, 6'b001000, 6'd0, 0, V_ADDIEX, "addi_ex");
        cyc(0, 6'b001000, 6'd0, 0, V_ADDIWB, "addi_wb");
        // j: 3 cycles
        cyc(0, 6'b000010, 6'd0, 0, V_FETCH,  "j_fetch");
        cyc(0, 6'b000010, 6'd0, 0, V_DECODE, "j_decode");
        cyc(0, 6'b000010, 6'd0, 0, V_JEX,    "j_ex");
        // unknown op behaves as a NOP
        cyc(0, 6'b111111, 6'd0, 0, V_FETCH,  "unk_fetch");
        cyc(0, 6'b111111, 6'd0, 0, V_DECODE, "unk_decode");
        // bne
        cyc(0, 6'b000101, 6'd0, 0, V_FETCH,  "bne_fetch");
        cyc(0, 6'b000101, 6'd0, 0, V_DECODE, "bne_decode");
`ifdef MULTICYCLE_CTRL_BNE_EN
        cyc(0, 6'b000101, 6'd0, 0, V_BEQ_T,  "bne_ex");
`endif
        // reset arriving in RTYPEEX abandons the instruction
        cyc(0, 6'b000000, 6'b100000, 0, V_FETCH,  "rst_fetch");
        cyc(0, 6'b000000, 6'b100000, 0, V_DECODE, "rst_decode");
        cyc(1, 6'b000000, 6'b100000, 0, V_RST,    "rst_in_ex");
        cyc(0, 6'b000000, 6'b100000, 0, V_FETCH,  "rst_after");
        cyc(0, 6'b000000, 6'b100000, 0, V_DECODE, "rst_after_dec");
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control unit that sequences the multicycle MIPS datapath: fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Drives every select and enable input of the datapath.
- Receives opcode, funct and the ALU zero flag back from the datapath.
- Sits beside the datapath inside the processor top level. Memory write enable goes to the external memory.

Parameters:
- STATE_W, 4, width of the state register (must hold all states, including the optional one).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag (combinational, current cycle).
- pcen  output  1  PC register enable = pcwrite OR (branch AND zero).
- memwrite  output  1  memory write enable.
- irwrite  output  1  instruction register load enable.
- regwrite  output  1  register file write enable.
- iord  output  1  address mux select: 0 = pc, 1 = aluout.
- memtoreg  output  1  writeback select: 0 = aluout, 1 = data register.
- regdst  output  1  destination select: 0 = rt, 1 = rd.
- alusrcA  output  1  ALU A select: 0 = pc, 1 = A register.
- alusrcB  output  2  ALU B select: 00 = B register, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  output  2  next-PC select: 00 = aluresult, 01 = aluout, 10 = jump target.
- alucontrol  output  3  ALU operation.

Behaviour:
- Reset (synchronous): on any rising edge with reset=1, state <= FETCH.
- While reset=1, the write enables (pcen, memwrite, irwrite, regwrite) are forced to 0 combinationally. All other outputs take their FETCH values.
- Reset asserted mid-instruction abandons that instruction. No partial write occurs in the reset cycle.
- Outputs are a combinational decode of the current state, except:
  - alucontrol also depends on funct.
  - pcen also depends on zero.
- Any output not listed for a state is 0. Internal aluop: 00 = add, 01 = sub, 10 = use funct.
- FETCH: iord=0, irwrite=1, alusrcA=0, alusrcB=01, aluop=00, pcsrc=00, pcwrite=1. Next state: DECODE.
- DECODE: alusrcA=0, alusrcB=11, aluop=00 (branch target captured into aluout). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> FETCH (executes as a NOP; no register or memory write).
- MEMADR: alusrcA=1, alusrcB=10, aluop=00. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state: MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state: FETCH.
- MEMWR: iord=1, memwrite=1. Next state: FETCH.
- RTYPEEX: alusrcA=1, alusrcB=00, aluop=10. Next state: RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next state: FETCH.
- BEQEX: alusrcA=1, alusrcB=00, aluop=01, pcsrc=01, branch=1. Next state: FETCH.
- ADDIEX: alusrcA=1, alusrcB=10, aluop=00. Next state: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state: FETCH.
- JEX: pcsrc=10, pcwrite=1. Next state: FETCH.
- ALU decode:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown funct -> 010 (add); result is still written back.
- Latency in cycles: lw 5; sw, R-type, addi 4; beq, j 3.
- Unreachable encodings of the state register recover to FETCH on the next edge.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BNE_EN.
- Defined: op 000101 in DECODE -> BNEEX.
  - BNEEX drives the same outputs as BEQEX, but pcen = pcwrite OR (branch_ne AND NOT zero).
  - Latency 3 cycles.
- Undefined: op 000101 is an unknown opcode (NOP, back to FETCH); state BNEEX is not present.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum typedef (STATE_W bits);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE);
  - funct constants;
  - alucontrol constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT);
  - aluop constants.
- One sub-module, mc_aludec: combinational aluop + funct -> alucontrol.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset: hold reset=1 for 2 edges with op=100011 -> pcen=memwrite=irwrite=regwrite=0 during reset; first cycle after release is FETCH (irwrite=1, pcen=1, alusrcB=01).
- lw (op=100011): exactly 5 cycles; MEMRD has iord=1; MEMWB has memtoreg=1, regwrite=1, regdst=0; FETCH follows.
- sw (op=101011): 4 cycles; memwrite=1 only in cycle 4 with iord=1; regwrite never 1.
- R-type, op=000000, each of funct 100000/100010/100100/100101/101010 -> alucontrol 010/110/000/001/111 in RTYPEEX; RTYPEWB has regdst=1, regwrite=1.
- beq, op=000100: zero=1 in BEQEX -> pcen=1, pcsrc=01; zero=0 -> pcen=0. Both return to FETCH after 3 cycles.
- j (op=000010) -> JEX with pcsrc=10, pcen=1. Unknown op 111111 -> back to FETCH after DECODE with no write enable. Reset asserted in RTYPEEX -> no regwrite occurs; FETCH on the next cycle.
